// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared helpers for pipelined_chunk_adder: chunk sizing, parameter legality
// and the packed layout of the per-stage B-operand skew registers.
package pipelined_chunk_adder_pkg;

   localparam int DEFAULT_N      = 8;
   localparam int DEFAULT_STAGES = 4;

   function automatic int chunk_width(input int n, input int stages);
      return (stages > 0) ? n / stages : n;
   endfunction

   function automatic bit params_ok(input int n, input int stages);
      return (n >= 1) && (stages >= 1) && ((n % stages) == 0);
   endfunction

   // Stage k keeps the B' chunks above chunk k; the regions are packed back to back.
   function automatic int skew_offset(input int n, input int stages, input int k);
      int off;
      off = 0;
      for (int j = 0; j < k; j++) begin
         off += n - (j + 1) * chunk_width(n, stages);
      end
      return off;
   endfunction

   function automatic int skew_width(input int n, input int stages);
      int w;
      w = skew_offset(n, stages, stages - 1);
      return (w > 0) ? w : 1;
   endfunction

endpackage

// File: rtl/pipelined_chunk_adder_chunk_adder.sv
// Combinational W-bit full adder; one instance resolves one chunk per pipeline stage.
module chunk_adder #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   end

   assign sum  = total[W-1:0];
   assign cout = total[W];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined N-bit adder/subtractor: one CHUNK-bit slice per stage with a registered
// carry between stages, valid/ready handshake and a global stall on output backpressure.
module pipelined_chunk_adder
   import pipelined_chunk_adder_pkg::*;
#(
   parameter int N      = DEFAULT_N,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_cout
);

   localparam int CHUNK  = chunk_width(N, STAGES);
   localparam int SKEW_W = skew_width(N, STAGES);

   if (!params_ok(N, STAGES)) begin : g_param_check
      $error("pipelined_chunk_adder: N must be >= 1 and a multiple of STAGES");
   end

   logic              adv;
   logic              in_fire;
   logic [N-1:0]      b_eff;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [SKEW_W-1:0] skew_q, skew_d, skew_next;
   logic [N-1:0]      word_q    [STAGES];
   logic [N-1:0]      word_d    [STAGES];
   logic [N-1:0]      word_next [STAGES];
   logic [N-1:0]      src_word  [STAGES];

   logic [STAGES-1:0] src_valid;
   logic [STAGES-1:0] cin_s;
   logic [STAGES-1:0] cout_s;
   logic [CHUNK-1:0]  op_a  [STAGES];
   logic [CHUNK-1:0]  op_b  [STAGES];
   logic [CHUNK-1:0]  sum_s [STAGES];

   assign adv      = !valid_q[STAGES-1] || out_ready;
   assign in_ready = adv;
   assign in_fire  = in_valid && adv;
   assign b_eff    = in_sub ? ~in_b : in_b;

   // The A word shifts its unconsumed chunks down while finished sum chunks enter
   // from the top, so after the last stage the word holds the complete result.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM_W = N - (k + 1) * CHUNK;

      if (k == 0) begin : g_src
         assign src_word[k]  = in_a;
         assign op_b[k]      = b_eff[CHUNK-1:0];
         assign cin_s[k]     = in_sub;
         assign src_valid[k] = in_fire;
      end else begin : g_src
         assign src_word[k]  = word_q[k-1];
         assign op_b[k]      = skew_q[skew_offset(N, STAGES, k - 1) +: CHUNK];
         assign cin_s[k]     = carry_q[k-1];
         assign src_valid[k] = valid_q[k-1];
      end

      assign op_a[k] = src_word[k][CHUNK-1:0];

      chunk_adder #(
         .W(CHUNK)
      ) u_chunk_adder (
         .a   (op_a[k]),
         .b   (op_b[k]),
         .cin (cin_s[k]),
         .sum (sum_s[k]),
         .cout(cout_s[k])
      );

      assign word_next[k] = (src_word[k] >> CHUNK) | (N'(sum_s[k]) << (N - CHUNK));

      if (k < STAGES - 1) begin : g_skew
         localparam int OFF = skew_offset(N, STAGES, k);
         logic [REM_W-1:0] rem;
         if (k == 0) begin : g_rem
            assign rem = b_eff[N-1:CHUNK];
         end else begin : g_rem
            assign rem = skew_q[skew_offset(N, STAGES, k - 1) + CHUNK +: REM_W];
         end
         assign skew_next[OFF +: REM_W] = src_valid[k] ? rem : '0;
      end
   end

   if (STAGES == 1) begin : g_no_skew
      assign skew_next = '0;
   end

   // Every stage advances together or holds together; bubbles load zeros.
   always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      skew_d  = skew_q;
      for (int k = 0; k < STAGES; k++) begin
         word_d[k] = word_q[k];
      end
      if (adv) begin
         valid_d = src_valid;
         carry_d = src_valid & cout_s;
         skew_d  = skew_next;
         for (int k = 0; k < STAGES; k++) begin
            word_d[k] = src_valid[k] ? word_next[k] : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         skew_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            word_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         skew_q  <= skew_d;
         for (int k = 0; k < STAGES; k++) begin
            word_q[k] <= word_d[k];
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign out_sum   = word_q[STAGES-1];
   assign out_cout  = carry_q[STAGES-1];

endmodule
